// File: rtl/run_slot_scheduler.sv
// Round-robin time-slice scheduler: one owner at a time, IDLE -> RUN -> STOP,
// each grant capped at SLICE cycles and followed by a GAP-cycle cooldown.
module run_slot_scheduler #(
  parameter int N_REQ = 4,
  parameter int SLICE = 16,
  parameter int GAP   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_done,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_running,
  output logic                     o_start_p,
  output logic                     o_stop_p,
  output logic                     o_preempt
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(SLICE + 1);
  localparam int GW  = $clog2(GAP + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_last;
  logic [CW-1:0]    r_slice_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_running;
  logic             r_start_p;
  logic             r_stop_p;
  logic             r_preempt;

  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_cand;
  logic [N_REQ-1:0] w_onehot;
  logic             w_found;
  logic             w_release;

  assign w_found   = |i_req;
  assign w_release = i_done[r_grant_id] | ~i_req[r_grant_id];

  // Round-robin pick: scan downward so the candidate nearest last+1 wins.
  always_comb begin
    w_sel  = r_last;
    w_cand = r_last;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IDW'((int'(r_last) + k) % N_REQ);
      w_sel  = i_req[w_cand] ? w_cand : w_sel;
    end
    w_onehot        = {N_REQ{1'b0}};
    w_onehot[w_sel] = 1'b1;
  end

  // Scheduler state, counters and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= {N_REQ{1'b0}};
      r_grant_id  <= {IDW{1'b0}};
      r_last      <= IDW'(N_REQ - 1);
      r_slice_cnt <= {CW{1'b0}};
      r_gap_cnt   <= {GW{1'b0}};
      r_running   <= 1'b0;
      r_start_p   <= 1'b0;
      r_stop_p    <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_start_p <= 1'b0;
      r_stop_p  <= 1'b0;
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_RUN;
            r_grant     <= w_onehot;
            r_grant_id  <= w_sel;
            r_last      <= w_sel;
            r_slice_cnt <= CW'(1);
            r_running   <= 1'b1;
            r_start_p   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          // Owner release outranks slice expiry, so a done on the last slice cycle is not a preempt.
          if (w_release || (r_slice_cnt == CW'(SLICE))) begin
            r_state   <= S_STOP;
            r_grant   <= {N_REQ{1'b0}};
            r_running <= 1'b0;
            r_stop_p  <= 1'b1;
            r_preempt <= ~w_release;
            r_gap_cnt <= GW'(1);
          end else begin
            r_slice_cnt <= r_slice_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_gap_cnt == GW'(GAP)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_grant   <= {N_REQ{1'b0}};
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant    = r_grant;
  assign o_grant_id = r_grant_id;
  assign o_running  = r_running;
  assign o_start_p  = r_start_p;
  assign o_stop_p   = r_stop_p;
  assign o_preempt  = r_preempt;

endmodule

// File: tb/tb_run_slot_scheduler.sv
// Scoreboard bench for run_slot_scheduler: a grant-level reference model queues
// expected start/stop events with cycle stamps; a monitor matches DUT pulses.
module tb_run_slot_scheduler;

  localparam int N    = 4;
  localparam int SL   = 4;
  localparam int GP   = 1;
  localparam int NCYC = 420;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_req = 4'b0000;
  logic [3:0] i_done = 4'b0000;
  logic [3:0] o_grant;
  logic [1:0] o_grant_id;
  logic       o_running, o_start_p, o_stop_p, o_preempt;

  run_slot_scheduler #(.N_REQ(N), .SLICE(SL), .GAP(GP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_done(i_done),
    .o_grant(o_grant), .o_grant_id(o_grant_id), .o_running(o_running),
    .o_start_p(o_start_p), .o_stop_p(o_stop_p), .o_preempt(o_preempt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {bit is_start; int stamp; int id; bit pre;} ev_t;
  ev_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 granted, 2 cooldown.
  int m_phase = 0, m_owner = -1, m_held = 0, m_left = 0, m_last = N - 1, m_grants = 0;

  task automatic m_step(input logic [3:0] rq, input logic [3:0] dn, input int stamp);
    ev_t e;
    bit  found;
    int  idx;
    found = 1'b0;
    case (m_phase)
      0: begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && rq[idx]) begin
            found = 1'b1; m_owner = idx; m_last = idx; m_held = 1; m_phase = 1; m_grants++;
            e = '{1'b1, stamp, idx, 1'b0}; sb.push_back(e);
          end
        end
      end
      1: begin
        if (dn[m_owner] || !rq[m_owner]) begin
          e = '{1'b0, stamp, m_owner, 1'b0}; sb.push_back(e); m_phase = 2; m_left = GP;
        end else if (m_held == SL) begin
          e = '{1'b0, stamp, m_owner, 1'b1}; sb.push_back(e); m_phase = 2; m_left = GP;
        end else m_held++;
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
  endtask

  // Monitor: matches pulses against the queue and checks grant levels every cycle.
  initial begin
    ev_t e;
    int  cur;
    bit  inrun;
    cur = 0; inrun = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        cur = 0; inrun = 1'b0;
      end else begin
        if (o_start_p) begin
          if (sb.size() == 0) chk("start_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("start_kind", e.is_start, 1);
            chk("start_cycle", cyc, e.stamp);
            chk("start_id", o_grant_id, e.id);
            cur = e.id; inrun = 1'b1;
          end
        end
        if (o_stop_p) begin
          if (sb.size() == 0) chk("stop_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("stop_kind", e.is_start, 0);
            chk("stop_cycle", cyc, e.stamp);
            chk("preempt", o_preempt, e.pre);
            inrun = 1'b0;
          end
        end else chk("preempt_without_stop", o_preempt, 0);
        chk("running", o_running, inrun);
        chk("grant", o_grant, inrun ? (1 << cur) : 0);
        chk("grant_id", o_grant_id, cur);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rq, dn, prev;
    bit dropped, rst_done;
    dropped = 1'b0; rst_done = 1'b0; prev = 4'b0000;
    #1;
    chk("reset_grant", o_grant, 0);
    chk("reset_grant_id", o_grant_id, 0);
    chk("reset_running", o_running, 0);
    chk("reset_pulses", {o_start_p, o_stop_p, o_preempt}, 0);
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge i_clk);
      #2;
      dn = 4'b0000;
      if (k < 10) rq = 4'b0000;
      else if (k < 40) rq = 4'b0100;
      else if (k < 80) rq = 4'b1111;
      else if (k < 120) begin
        rq = 4'b0010;
        if (m_phase == 1 && m_held == ((m_grants % 2) ? 2 : SL)) dn = 4'b0010;
      end else if (k < 150) begin
        if (!dropped && m_phase == 1 && m_owner == 3 && m_held == 2) dropped = 1'b1;
        rq = dropped ? 4'b0001 : 4'b1000;
      end else if (k < 190) begin
        rq = rst_done ? 4'b0110 : 4'b0100;
        if (!rst_done && m_phase == 1 && m_held == 2) begin
          i_rst_n = 1'b0;
          sb.delete();
          #1;
          chk("midrun_reset_grant", o_grant, 0);
          chk("midrun_reset_running", o_running, 0);
          chk("midrun_reset_pulses", {o_start_p, o_stop_p, o_preempt}, 0);
          m_phase = 0; m_owner = -1; m_last = N - 1;
          repeat (2) @(posedge i_clk);
          #2;
          rq = 4'b0110;
          i_rst_n = 1'b1;
          rst_done = 1'b1;
        end
      end else begin
        rq = prev;
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
          dn[b] = ($urandom_range(0, 7) == 0);
        end
      end
      prev = rq;
      i_req = rq;
      i_done = dn;
      m_step(rq, dn, cyc + 1);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clk);
      #2;
      i_req = 4'b0000; i_done = 4'b0000;
      m_step(4'b0000, 4'b0000, cyc + 1);
    end
    @(posedge i_clk);
    #6;
    chk("scoreboard_drained", sb.size(), 0);
    chk("midrun_reset_exercised", rst_done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
